// File: rtl/unary_expander.sv
// unary_expander: captures a 2-bit count from active-low PMOD buttons on a
// debounced load press, then fills a thermometer LED display one step at a
// time, holds it for HOLD_STEPS steps, and clears it.
module unary_expander #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_CYCLES     = 3000000,
  parameter int HOLD_STEPS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pmod,
  output logic [2:0] led,
  output logic       busy
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = $clog2(STEP_CYCLES);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_END  = HW'(HOLD_STEPS);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  logic [2:0]    sync1, sync2;
  logic [2:0]    btn;
  logic [DW-1:0] db_cnt;
  logic          db, db_q, press;
  state_t        state, state_n;
  logic [1:0]    lit, lit_n, target, target_n, lit_inc;
  logic [TW-1:0] timer, timer_n;
  logic [HW-1:0] hold, hold_n, hold_inc;
  logic          tick;

  function automatic logic [2:0] therm(input logic [1:0] n);
    case (n)
      2'd0:    therm = 3'b000;
      2'd1:    therm = 3'b001;
      2'd2:    therm = 3'b011;
      default: therm = 3'b111;
    endcase
  endfunction

  // Two-flop synchronizer; reset value is "all buttons released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= pmod;
      sync2 <= sync1;
    end
  end

  assign btn = ~sync2;

  // Load debounce: level flips only after DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db     <= 1'b0;
    end else if (btn[2] != db) begin
      if (db_cnt == DB_LAST) begin
        db     <= ~db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Edge register; press is a one-cycle pulse on the debounced rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_q <= 1'b0;
    else     db_q <= db;
  end

  assign press    = db & ~db_q;
  assign tick     = (timer == '0);
  assign lit_inc  = lit + 2'd1;
  assign hold_inc = hold + HW'(1);

  // Next-state logic; press edges outside IDLE fall through and are dropped.
  always_comb begin
    state_n  = state;
    lit_n    = lit;
    target_n = target;
    timer_n  = timer;
    hold_n   = hold;
    case (state)
      IDLE: begin
        if (press) begin
          target_n = btn[1:0];
          lit_n    = 2'd0;
          timer_n  = STEP_LAST;
          hold_n   = '0;
          state_n  = (btn[1:0] != 2'd0) ? FILL : HOLD;
        end
      end
      FILL: begin
        timer_n = tick ? STEP_LAST : timer - TW'(1);
        if (tick) begin
          lit_n = lit_inc;
          if (lit_inc == target) begin
            state_n = HOLD;
            hold_n  = '0;
          end
        end
      end
      HOLD: begin
        timer_n = tick ? STEP_LAST : timer - TW'(1);
        if (tick) begin
          hold_n = hold_inc;
          if (hold_inc == HOLD_END) begin
            lit_n   = 2'd0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; led/busy follow the next values so they
  // change on the same edge as lit/state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lit    <= 2'd0;
      target <= 2'd0;
      timer  <= '0;
      hold   <= '0;
      led    <= 3'b000;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      lit    <= lit_n;
      target <= target_n;
      timer  <= timer_n;
      hold   <= hold_n;
      led    <= therm(lit_n);
      busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_unary_expander.sv
// Directed bench for unary_expander with a cycle-stamped scoreboard of
// expected led/busy values, compared on the falling clock edge.
module tb_unary_expander;

  localparam int DB   = 4;
  localparam int STEP = 8;
  localparam int HOLDS = 2;
  localparam int LAT  = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pmod;
  logic [2:0] led;
  logic       busy;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int         at;
    logic [2:0] led;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t q[$];

  unary_expander #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(STEP), .HOLD_STEPS(HOLDS)) dut (
    .clk(clk), .rst(rst), .pmod(pmod), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] therm(input int n);
    case (n)
      0:       therm = 3'b000;
      1:       therm = 3'b001;
      2:       therm = 3'b011;
      default: therm = 3'b111;
    endcase
  endfunction

  task automatic push(input int at, input logic [2:0] l, input logic b, input string tag);
    exp_t e;
    e.at = at; e.led = l; e.busy = b; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [2:0] l, input logic b);
    total++;
    assert ({led, busy} === {l, b}) passed++;
    else $error("FAIL %s @cyc %0d: led=%b busy=%b, expected led=%b busy=%b",
                tag, cyc, led, busy, l, b);
  endtask

  // Compare every scoreboard entry due at this cycle; late entries are failures.
  task automatic drain();
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.at == cyc) begin
        check(e.tag, e.led, e.busy);
      end else begin
        total++;
        $error("FAIL %s missed: due cyc %0d, now %0d", e.tag, e.at, cyc);
      end
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      drain();
    end
  endtask

  // Expected trace of a whole sequence captured at cycle c for count n.
  task automatic seq_expect(input int c, input int n, input string tag);
    int e;
    e = c + STEP * (n + HOLDS);
    push(c - 1, 3'b000, 1'b0, {tag, "_pre"});
    push(c, 3'b000, 1'b1, {tag, "_cap"});
    for (int k = 1; k <= n; k++) begin
      push(c + STEP * k - 1, therm(k - 1), 1'b1, {tag, "_fill_before"});
      push(c + STEP * k, therm(k), 1'b1, {tag, "_fill"});
    end
    if (n == 0) push(c + STEP, 3'b000, 1'b1, {tag, "_zero_mid"});
    push(e - 1, therm(n), 1'b1, {tag, "_hold_end"});
    push(e, 3'b000, 1'b0, {tag, "_idle"});
  endtask

  initial begin
    int c;
    int cb;
    rst  = 1'b1;
    pmod = 3'b111;
    @(negedge clk);
    check("reset_a", 3'b000, 1'b0);
    @(negedge clk);
    check("reset_b", 3'b000, 1'b0);
    rst = 1'b0;
    run_to(cyc + 3);

    // Count 3, released after capture.
    pmod = 3'b000;
    c = cyc + LAT;
    seq_expect(c, 3, "cnt3");
    run_to(c + 1);
    pmod = 3'b111;
    run_to(c + 45);

    // Count 0: display stays dark, busy for two hold steps.
    pmod = 3'b011;
    c = cyc + LAT;
    seq_expect(c, 0, "cnt0");
    run_to(c + 1);
    pmod = 3'b111;
    run_to(c + 25);

    // Bounce on load: never stable long enough to capture.
    cb = cyc;
    push(cb + 5, 3'b000, 1'b0, "bounce_a");
    push(cb + 12, 3'b000, 1'b0, "bounce_b");
    push(cb + 19, 3'b000, 1'b0, "bounce_c");
    push(cb + 26, 3'b000, 1'b0, "bounce_d");
    for (int i = 0; i < 10; i++) begin
      pmod = (i % 2 == 0) ? 3'b011 : 3'b111;
      run_to(cyc + 2);
    end
    pmod = 3'b111;
    run_to(cb + 28);
    pmod = 3'b001;
    c = cyc + LAT;
    seq_expect(c, 2, "after_bounce");
    run_to(c + 1);
    pmod = 3'b111;
    run_to(c + 40);

    // Second press during FILL is ignored.
    pmod = 3'b000;
    c = cyc + LAT;
    seq_expect(c, 3, "ignore");
    run_to(c + 1);
    pmod = 3'b111;
    run_to(c + 10);
    pmod = 3'b010;
    run_to(c + 30);
    pmod = 3'b111;
    push(c + 41, 3'b000, 1'b0, "ignore_idle_a");
    push(c + 55, 3'b000, 1'b0, "ignore_idle_b");
    run_to(c + 56);

    // Load held through the sequence: one run only.
    pmod = 3'b001;
    c = cyc + LAT;
    seq_expect(c, 2, "held");
    push(c + 33, 3'b000, 1'b0, "held_idle_a");
    push(c + 45, 3'b000, 1'b0, "held_idle_b");
    run_to(c + 45);
    pmod = 3'b111;
    run_to(c + 55);

    // Release then re-press starts a new sequence.
    pmod = 3'b010;
    c = cyc + LAT;
    seq_expect(c, 1, "repress");
    run_to(c + 1);
    pmod = 3'b111;
    run_to(c + 30);

    // Reset mid-FILL aborts asynchronously.
    pmod = 3'b000;
    c = cyc + LAT;
    push(c - 1, 3'b000, 1'b0, "rstseq_pre");
    push(c, 3'b000, 1'b1, "rstseq_cap");
    push(c + 8, 3'b001, 1'b1, "rstseq_fill");
    push(c + 12, 3'b001, 1'b1, "rstseq_mid");
    run_to(c + 12);
    rst  = 1'b1;
    pmod = 3'b111;
    #1;
    check("rst_async", 3'b000, 1'b0);
    run_to(cyc + 1);
    rst = 1'b0;
    push(cyc + 4, 3'b000, 1'b0, "post_rst_idle");
    run_to(cyc + 6);
    pmod = 3'b010;
    c = cyc + LAT;
    seq_expect(c, 1, "post_rst");
    run_to(c + 1);
    pmod = 3'b111;
    run_to(c + 30);

    if (q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_left: %0d entries pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
